// File: rtl/kbd_seg_ctrl_pkg.sv
// Shared types, scan-code constants and the scan-code to ASCII lookup for the keyboard display path.
// Latency: none; it holds only declarations and a pure function.
// Backpressure: not applicable.
package kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DP    = 8'h80;
  localparam logic [7:0] SEG_ZERO  = 8'hC0;

  // Set-2 scan code to ASCII; unknown codes return 0 so the display can blank them.
  function automatic logic [7:0] scan2ascii(input logic [7:0] code, input logic shift);
    logic [7:0] a;
    case (code)
      8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
      8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
      8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
      8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
      8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
      8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
      8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
      8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
      8'h3E: a = 8'h38;  8'h46: a = 8'h39;
      8'h29: a = 8'h20;  8'h5A: a = 8'h0D;
      default: a = 8'h00;
    endcase
    if (shift && (a >= 8'h61) && (a <= 8'h7A)) a = a - 8'h20;
    return a;
  endfunction

endpackage

// File: rtl/kbd_seg_ctrl_if.sv
// Read side of the keyboard FIFO: head-of-queue data, ready, overflow and the active-low pop strobe.
// Latency: wires only.
// Backpressure: the consumer pops at its own pace via ps2_nextdata_n; the FIFO holds data until popped.
interface kbd_seg_ctrl_if;
  logic       ps2_ready;
  logic [7:0] ps2_data;
  logic       ps2_overflow;
  logic       ps2_nextdata_n;

  modport master (output ps2_ready, ps2_data, ps2_overflow, input ps2_nextdata_n);
  modport slave  (input ps2_ready, ps2_data, ps2_overflow, output ps2_nextdata_n);
endinterface

// File: rtl/kbd_seg_ctrl_hex7seg.sv
// One hex nibble to active-low 7-segment pattern (bit0=a .. bit6=g, bit7=dp kept dark).
// Latency: combinational.
// Backpressure: none.
module hex7seg (
  input  logic [3:0] i_nib,
  output logic [7:0] o_seg
);

  // Fixed glyph table, dp always off.
  always_comb begin
    o_seg = 8'hFF;
    case (i_nib)
      4'h0: o_seg = 8'hC0;  4'h1: o_seg = 8'hF9;  4'h2: o_seg = 8'hA4;  4'h3: o_seg = 8'hB0;
      4'h4: o_seg = 8'h99;  4'h5: o_seg = 8'h92;  4'h6: o_seg = 8'h82;  4'h7: o_seg = 8'hF8;
      4'h8: o_seg = 8'h80;  4'h9: o_seg = 8'h90;  4'hA: o_seg = 8'h88;  4'hB: o_seg = 8'h83;
      4'hC: o_seg = 8'hC6;  4'hD: o_seg = 8'hA1;  4'hE: o_seg = 8'h86;  4'hF: o_seg = 8'h8E;
      default: o_seg = 8'hFF;
    endcase
  end

endmodule

// File: rtl/kbd_seg_ctrl.sv
// Pops scan codes from the keyboard FIFO, tracks the held key and drives eight 7-segment digits.
// Latency: pop strobe 1 edge after ready seen, key state 2 edges, display 3 edges; optional KBD_SHIFT_EN.
// Backpressure: one pop per IDLE-POP-GAP round; FIFO is never sampled during POP/GAP.
module kbd_seg_ctrl
  import kbd_pkg::*;
#(
  parameter int GAP_CYCLES       = 2,
  parameter bit BLANK_ON_RELEASE = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  kbd_seg_ctrl_if.slave  bus,
  output logic [7:0]     o_seg0,
  output logic [7:0]     o_seg1,
  output logic [7:0]     o_seg2,
  output logic [7:0]     o_seg3,
  output logic [7:0]     o_seg4,
  output logic [7:0]     o_seg5,
  output logic [7:0]     o_seg6,
  output logic [7:0]     o_seg7
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  state_t        r_state, w_state_nxt;
  logic          w_pop_take, w_decode, w_in_gap;
  logic          r_nextdata_n;
  logic [7:0]    r_code;
  logic [GW-1:0] r_gap;
  logic          r_held, r_brk, r_ext, r_ovf;
  logic [7:0]    r_cur, r_cnt;
  logic          w_shift;
  logic [7:0]    w_ascii;
  logic          w_blank_code, w_blank_asc;
  logic [3:0]    w_nib [6];
  logic [7:0]    w_hex [6];

`ifdef KBD_SHIFT_EN
  logic          r_shift;
  assign w_shift = r_shift;
`else
  assign w_shift = 1'b0;
`endif

  assign bus.ps2_nextdata_n = r_nextdata_n;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state: exactly one POP cycle, then GAP_CYCLES of GAP.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.ps2_ready) w_state_nxt = ST_POP;
      ST_POP:  w_state_nxt = ST_GAP;
      ST_GAP:  if (r_gap == '0) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM decoded controls.
  always_comb begin
    w_pop_take = (r_state == ST_IDLE) && bus.ps2_ready;
    w_decode   = (r_state == ST_POP);
    w_in_gap   = (r_state == ST_GAP);
  end

  // Registered pop strobe, captured code and gap down-counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_nextdata_n <= 1'b1;
      r_code       <= 8'h00;
      r_gap        <= '0;
    end else begin
      r_nextdata_n <= !w_pop_take;
      if (w_pop_take) r_code <= bus.ps2_data;
      if (w_decode) r_gap <= GAP_LOAD;
      else if (w_in_gap && (r_gap != '0)) r_gap <= r_gap - GW'(1);
    end
  end

  // Key tracking: prefix flags, held key and press counter (typematic repeats do not count).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_held <= 1'b0;
      r_brk  <= 1'b0;
      r_ext  <= 1'b0;
      r_cur  <= 8'h00;
      r_cnt  <= 8'h00;
`ifdef KBD_SHIFT_EN
      r_shift <= 1'b0;
`endif
    end else if (w_decode) begin
      if (r_code == SC_EXT) begin
        r_ext <= 1'b1;
      end else if (r_code == SC_BRK) begin
        r_brk <= 1'b1;
`ifdef KBD_SHIFT_EN
      end else if ((r_code == SC_LSHIFT) || (r_code == SC_RSHIFT)) begin
        r_shift <= !r_brk;
        r_brk   <= 1'b0;
        r_ext   <= 1'b0;
`endif
      end else if (r_brk) begin
        if ((r_code == r_cur) && r_held) r_held <= 1'b0;
        r_brk <= 1'b0;
        r_ext <= 1'b0;
      end else begin
        if (!r_held || (r_code != r_cur)) r_cnt <= r_cnt + 8'h01;
        r_cur  <= r_code;
        r_held <= 1'b1;
        r_ext  <= 1'b0;
      end
    end
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)                   r_ovf <= 1'b0;
    else if (bus.ps2_overflow) r_ovf <= 1'b1;
  end

  assign w_ascii      = scan2ascii(r_cur, w_shift);
  assign w_blank_code = !r_held && BLANK_ON_RELEASE;
  assign w_blank_asc  = w_blank_code || (w_ascii == 8'h00);

  assign w_nib[0] = r_cur[3:0];
  assign w_nib[1] = r_cur[7:4];
  assign w_nib[2] = w_ascii[3:0];
  assign w_nib[3] = w_ascii[7:4];
  assign w_nib[4] = r_cnt[3:0];
  assign w_nib[5] = r_cnt[7:4];

  for (genvar g = 0; g < 6; g++) begin : g_hex
    hex7seg u_hex (.i_nib(w_nib[g]), .o_seg(w_hex[g]));
  end

  // Display registers, one edge behind the key state.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_seg0 <= SEG_BLANK;
      o_seg1 <= SEG_BLANK;
      o_seg2 <= SEG_BLANK;
      o_seg3 <= SEG_BLANK;
      o_seg4 <= SEG_ZERO;
      o_seg5 <= SEG_ZERO;
      o_seg6 <= SEG_BLANK;
      o_seg7 <= SEG_BLANK;
    end else begin
      o_seg0 <= w_blank_code ? SEG_BLANK : w_hex[0];
      o_seg1 <= w_blank_code ? SEG_BLANK : w_hex[1];
      o_seg2 <= w_blank_asc  ? SEG_BLANK : w_hex[2];
      o_seg3 <= w_blank_asc  ? SEG_BLANK : w_hex[3];
      o_seg4 <= w_hex[4];
      o_seg5 <= w_hex[5];
      o_seg6 <= SEG_BLANK;
      o_seg7 <= r_ovf ? (SEG_BLANK & ~SEG_DP) : SEG_BLANK;
    end
  end

endmodule
